// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: valid/ready on both sides,
// operands and opcode in, registered result and flags out.
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [OPW-1:0]   ALUop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUresult;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, A, B, ALUop, out_ready,
    input  in_ready, out_valid, ALUresult, zero, carry, overflow, illegal
  );

  modport slave (
    input  in_valid, A, B, ALUop, out_ready,
    output in_ready, out_valid, ALUresult, zero, carry, overflow, illegal
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 registers operands, S2 computes and registers
// result and flags. Valid/ready flow control with back-pressure and flush.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  alu_pipe_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOR  = 3'd5,
    OP_SLTU = 3'd6,
    OP_SLT  = 3'd7
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OPW-1:0]   s1_op;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_carry;
  logic             s2_overflow;
  logic             s2_illegal;

  logic             s2_load;
  logic             s1_move;
  logic             in_ready;
  logic             accept;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;
  logic             ill_c;

  // NOTE: combinational logic uses blocking '=' so later lines see the
  // values computed above them within the same evaluation.
  always_comb begin
    s2_load  = !s2_valid || bus.out_ready;
    s1_move  = s1_valid && s2_load;
    in_ready = !s1_valid || s2_load;
    accept   = bus.in_valid && in_ready;
  end

  // Subtraction as A + ~B + 1 so bit WIDTH is the inverted borrow.
  assign sum  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff = {1'b0, s1_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    ill_c   = 1'b0;
    case (s1_op)
      OP_AND:  res_c = s1_a & s1_b;
      OP_OR:   res_c = s1_a | s1_b;
      OP_ADD: begin
        res_c   = sum[MSB:0];
        carry_c = sum[WIDTH];
        ovf_c   = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        res_c   = diff[MSB:0];
        carry_c = !diff[WIDTH];
        ovf_c   = (s1_a[MSB] == ~s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
      end
      OP_XOR:  res_c = s1_a ^ s1_b;
      OP_NOR:  res_c = ~(s1_a | s1_b);
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      default: ill_c = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values and the two stages shift cleanly in the same edge.
  // NOTE: the operand registers are reset too; they are few and a known
  // value keeps the S2 inputs deterministic straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= bus.A;
      s1_b     <= bus.B;
      s1_op    <= bus.ALUop;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      s2_result   <= '0;
      s2_zero     <= 1'b1;
      s2_carry    <= 1'b0;
      s2_overflow <= 1'b0;
      s2_illegal  <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s1_move) begin
      s2_valid    <= 1'b1;
      s2_result   <= res_c;
      s2_zero     <= (res_c == '0);
      s2_carry    <= carry_c;
      s2_overflow <= ovf_c;
      s2_illegal  <= ill_c;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.ALUresult = s2_result;
  assign bus.zero      = s2_zero;
  assign bus.carry     = s2_carry;
  assign bus.overflow  = s2_overflow;
  assign bus.illegal   = s2_illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus a randomized
// stream scored against an arithmetic reference model.
module tb_alu_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(32)) bus32 ();
  alu_pipe_if #(.WIDTH(8))  bus8 ();

  alu_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32.slave));
  alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus8.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    longint unsigned res;
    bit z;
    bit c;
    bit v;
  } exp_t;

  // Reference: values treated as integers, results reduced modulo 2^w.
  function automatic exp_t model(longint unsigned a, longint unsigned b, int op, int w);
    exp_t e;
    longint unsigned mask = (64'd1 << w) - 1;
    longint sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    longint sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    longint smax = (longint'(1) << (w-1)) - 1;
    longint smin = -(longint'(1) << (w-1));
    longint s;
    e.c = 0;
    e.v = 0;
    case (op)
      0: e.res = a & b;
      1: e.res = a | b;
      2: begin
        e.res = (a + b) & mask;
        e.c   = ((a + b) >> w) != 0;
        s     = sa + sb;
        e.v   = (s > smax) || (s < smin);
      end
      3: begin
        e.res = (a - b) & mask;
        e.c   = a < b;
        s     = sa - sb;
        e.v   = (s > smax) || (s < smin);
      end
      4: e.res = a ^ b;
      5: e.res = ~(a | b) & mask;
      6: e.res = (a < b) ? 1 : 0;
      default: e.res = (sa < sb) ? 1 : 0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive32(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus32.in_valid = v;
    bus32.A        = a;
    bus32.B        = b;
    bus32.ALUop    = op;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({bus32.out_valid, bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow, bus32.illegal}
        !== {1'b0, 32'h0, 4'b1000}) begin
      n_fail++;
      $display("FAIL reset32: got v=%b r=%h zcvi=%b%b%b%b want v=0 r=0 zcvi=1000", bus32.out_valid,
               bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow, bus32.illegal);
    end
    n_checks++;
    if ({bus8.out_valid, bus8.ALUresult, bus8.zero, bus8.carry, bus8.overflow, bus8.illegal}
        !== {1'b0, 8'h0, 4'b1000}) begin
      n_fail++;
      $display("FAIL reset8: got v=%b r=%h zcvi=%b%b%b%b want v=0 r=0 zcvi=1000", bus8.out_valid,
               bus8.ALUresult, bus8.zero, bus8.carry, bus8.overflow, bus8.illegal);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", bus32.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    bus32.out_ready = 1'b1;
    drive32(1'b1, 32'd5, 32'd5, 3'd3);
    @(negedge clk);
    drive32(1'b0, 32'd0, 32'd0, 3'd0);
    n_checks++;
    if (bus32.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: out_valid got %b want 0 after accepting edge", bus32.out_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({bus32.out_valid, bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow, bus32.illegal}
        !== {1'b1, 32'h0, 4'b1000}) begin
      n_fail++;
      $display("FAIL single_sub: got v=%b r=%h zcvi=%b%b%b%b want v=1 r=0 zcvi=1000", bus32.out_valid,
               bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow, bus32.illegal);
    end
    @(negedge clk);
    n_checks++;
    if (bus32.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: out_valid got %b want 0", bus32.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] tb [4] = '{32'h1, 32'h1, 32'h1, 32'h1};
    logic [2:0]  top[4] = '{3'd2, 3'd3, 3'd7, 3'd6};
    logic [31:0] er [4] = '{32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0};
    logic [2:0]  ef [4] = '{3'b110, 3'b001, 3'b000, 3'b100};
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        n_checks++;
        if ({bus32.out_valid, bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow}
            !== {1'b1, er[i-2], ef[i-2]}) begin
          n_fail++;
          $display("FAIL b2b_%0d: got v=%b r=%h zcv=%b%b%b want v=1 r=%h zcv=%b", i-2, bus32.out_valid,
                   bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow, er[i-2], ef[i-2]);
        end
      end
      if (i < 4) drive32(1'b1, ta[i], tb[i], top[i]);
      else       drive32(1'b0, 32'd0, 32'd0, 3'd0);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bus32.out_ready = 1'b0;
    drive32(1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 3'd4);
    #1;
    n_checks++;
    if (bus32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept1: in_ready got %b want 1", bus32.in_ready);
    end
    @(negedge clk);
    drive32(1'b1, 32'h0, 32'h0, 3'd5);
    #1;
    n_checks++;
    if (bus32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept2: in_ready got %b want 1", bus32.in_ready);
    end
    @(negedge clk);
    drive32(1'b1, 32'd1, 32'd1, 3'd2);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({bus32.out_valid, bus32.in_ready, bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow}
          !== {1'b1, 1'b0, 32'h0000_FF00, 3'b000}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b rdy=%b r=%h zcv=%b%b%b want v=1 rdy=0 r=0000ff00 zcv=000", k,
                 bus32.out_valid, bus32.in_ready, bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow);
      end
      if (k < 3) @(negedge clk);
    end
    bus32.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: in_ready got %b want 1", bus32.in_ready);
    end
    @(negedge clk);
    drive32(1'b0, 32'd0, 32'd0, 3'd0);
    n_checks++;
    if ({bus32.out_valid, bus32.ALUresult, bus32.zero} !== {1'b1, 32'hFFFF_FFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_nor: got v=%b r=%h z=%b want v=1 r=ffffffff z=0", bus32.out_valid,
               bus32.ALUresult, bus32.zero);
    end
    @(negedge clk);
    n_checks++;
    if ({bus32.out_valid, bus32.ALUresult} !== {1'b1, 32'd2}) begin
      n_fail++;
      $display("FAIL bp_third: got v=%b r=%h want v=1 r=00000002", bus32.out_valid, bus32.ALUresult);
    end
    @(negedge clk);
    n_checks++;
    if (bus32.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_dup: out_valid got %b want 0", bus32.out_valid);
    end
  endtask

  task automatic test_flush();
    bus32.out_ready = 1'b1;
    drive32(1'b1, 32'd7, 32'd7, 3'd2);
    flush = 1'b1;
    #1;
    n_checks++;
    if (bus32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_in_ready: got %b want 1", bus32.in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    drive32(1'b0, 32'd0, 32'd0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bus32.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_drop_%0d: out_valid got %b want 0", k, bus32.out_valid);
      end
      @(negedge clk);
    end
    bus32.out_ready = 1'b0;
    drive32(1'b1, 32'h0F, 32'h03, 3'd0);
    @(negedge clk);
    drive32(1'b1, 32'hF0, 32'h01, 3'd1);
    @(negedge clk);
    drive32(1'b0, 32'd0, 32'd0, 3'd0);
    n_checks++;
    if ({bus32.out_valid, bus32.in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_full: got v=%b rdy=%b want v=1 rdy=0", bus32.out_valid, bus32.in_ready);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if ({bus32.out_valid, bus32.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_clear: got v=%b rdy=%b want v=0 rdy=1", bus32.out_valid, bus32.in_ready);
    end
    bus32.out_ready = 1'b1;
    drive32(1'b1, 32'd2, 32'd3, 3'd2);
    @(negedge clk);
    drive32(1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    n_checks++;
    if ({bus32.out_valid, bus32.ALUresult} !== {1'b1, 32'd5}) begin
      n_fail++;
      $display("FAIL flush_after: got v=%b r=%h want v=1 r=00000005", bus32.out_valid, bus32.ALUresult);
    end
    @(negedge clk);
    n_checks++;
    if (bus32.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_tail: out_valid got %b want 0", bus32.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus32.out_ready = 1'b0;
    drive32(1'b1, 32'd10, 32'd3, 3'd3);
    @(negedge clk);
    drive32(1'b1, 32'd1, 32'd2, 3'd2);
    @(negedge clk);
    drive32(1'b0, 32'd0, 32'd0, 3'd0);
    n_checks++;
    if ({bus32.out_valid, bus32.ALUresult} !== {1'b1, 32'd7}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got v=%b r=%h want v=1 r=00000007", bus32.out_valid, bus32.ALUresult);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus32.out_valid, bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow, bus32.illegal}
        !== {1'b0, 32'h0, 4'b1000}) begin
      n_fail++;
      $display("FAIL rstmid_async: got v=%b r=%h zcvi=%b%b%b%b want v=0 r=0 zcvi=1000", bus32.out_valid,
               bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow, bus32.illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus32.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_emit_%0d: out_valid got %b want 0", k, bus32.out_valid);
      end
    end
  endtask

  task automatic test_width8();
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.A = 8'h7F; bus8.B = 8'h01; bus8.ALUop = 3'd2;
    @(negedge clk);
    bus8.A = 8'h00; bus8.B = 8'h01; bus8.ALUop = 3'd3;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    n_checks++;
    if ({bus8.out_valid, bus8.ALUresult, bus8.zero, bus8.carry, bus8.overflow} !== {1'b1, 8'h80, 3'b001}) begin
      n_fail++;
      $display("FAIL w8_add: got v=%b r=%h zcv=%b%b%b want v=1 r=80 zcv=001", bus8.out_valid,
               bus8.ALUresult, bus8.zero, bus8.carry, bus8.overflow);
    end
    @(negedge clk);
    n_checks++;
    if ({bus8.out_valid, bus8.ALUresult, bus8.zero, bus8.carry, bus8.overflow} !== {1'b1, 8'hFF, 3'b010}) begin
      n_fail++;
      $display("FAIL w8_sub: got v=%b r=%h zcv=%b%b%b want v=1 r=ff zcv=010", bus8.out_valid,
               bus8.ALUresult, bus8.zero, bus8.carry, bus8.overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic        exp_rdy;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (bus32.out_valid) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious: out_valid=1 r=%h with nothing in flight", bus32.ALUresult);
        end else begin
          e = q[0];
          if ({bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow, bus32.illegal}
              !== {e.res[31:0], e.z, e.c, e.v, 1'b0}) begin
            n_fail++;
            $display("FAIL rand_result: cyc %0d got r=%h zcvi=%b%b%b%b want r=%h zcvi=%b%b%b0", cyc,
                     bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow, bus32.illegal,
                     e.res[31:0], e.z, e.c, e.v);
          end
        end
      end
      a  = pick32();
      b  = pick32();
      op = 3'($urandom_range(0, 7));
      drive32(($urandom_range(0, 3) != 0), a, b, op);
      bus32.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = (q.size() < 2) || bus32.out_ready;
      n_checks++;
      if (bus32.in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_in_ready: cyc %0d got %b want %b", cyc, bus32.in_ready, exp_rdy);
      end
      if (bus32.out_valid && bus32.out_ready && q.size() > 0) void'(q.pop_front());
      if (bus32.in_valid && bus32.in_ready) q.push_back(model(64'(a), 64'(b), int'(op), 32));
      @(negedge clk);
    end
    drive32(1'b0, 32'd0, 32'd0, 3'd0);
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      if (bus32.out_valid) begin
        e = q.pop_front();
        n_checks++;
        if ({bus32.ALUresult, bus32.zero, bus32.carry, bus32.overflow} !== {e.res[31:0], e.z, e.c, e.v}) begin
          n_fail++;
          $display("FAIL rand_drain: got r=%h zcv=%b%b%b want r=%h zcv=%b%b%b", bus32.ALUresult,
                   bus32.zero, bus32.carry, bus32.overflow, e.res[31:0], e.z, e.c, e.v);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_lost: %0d ops never emitted, want 0", q.size());
    end
  endtask

  initial begin
    drive32(1'b0, 32'd0, 32'd0, 3'd0);
    bus32.out_ready = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.A          = '0;
    bus8.B          = '0;
    bus8.ALUop      = '0;
    bus8.out_ready  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_width8();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end

endmodule
